// File: rtl/mdb_pkg.sv
// ----------------------------------------------------------------------------
// mdb_pkg
//   Shared definitions for the multi-drop bus hub: broadcast policy encodings,
//   the drop-index type and a clog2 helper that never returns 0. The helper is
//   used to size address, pointer and count fields.
// ----------------------------------------------------------------------------
package mdb_pkg;

    // Broadcast policy selectors for the hub's BCAST_MODE parameter.
    localparam int BCAST_ATOMIC = 0;  // stall until every drop has space
    localparam int BCAST_BEST   = 1;  // write non-full drops, flag the others

    // Largest supported drop count. A 4-bit index covers it.
    localparam int MAX_DROPS = 16;
    typedef logic [3:0] drop_idx_t;

    // Ceiling log2 clamped to a minimum of 1 so that no field collapses to
    // zero width (for example a count field when DEPTH+1 is small).
    function automatic int clog2_safe(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mdb_drop_fifo.sv
// ----------------------------------------------------------------------------
// mdb_drop_fifo
//   Per-drop receive FIFO. DEPTH must be a power of two, so pointers wrap
//   naturally. Occupancy is tracked in an explicit counter (0..DEPTH), which
//   avoids ambiguity between the full and empty states.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset (clears pointers and count)
//   push_i   in   write wdata_i at the tail (ignored when full)
//   wdata_i  in   WIDTH-bit word to write
//   pop_i    in   remove the head word (ignored when empty)
//   rdata_o  out  head word, or 0 when empty
//   count_o  out  occupancy, CW = clog2(DEPTH+1) bits
//   full_o   out  count == DEPTH
//   empty_o  out  count == 0
// ----------------------------------------------------------------------------
module mdb_drop_fifo
    import mdb_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int CW    = clog2_safe(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = clog2_safe(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full, empty;
    logic             push_ok, pop_ok;

    always_comb begin
        full    = (count_q == CW'(DEPTH));
        empty   = (count_q == '0);
        // A pop on an empty FIFO is dropped even if a push lands in the
        // same cycle: the new word cannot fall through.
        push_ok = push_i & ~full;
        pop_ok  = pop_i & ~empty;

        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop_ok) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset. Stale entries are unreachable while count is 0,
    // and the output is masked when empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    assign rdata_o = empty ? '0 : mem_q[rptr_q];
    assign count_o = count_q;
    assign full_o  = full;
    assign empty_o = empty;

endmodule

// File: rtl/multi_drop_bus_hub.sv
// ----------------------------------------------------------------------------
// multi_drop_bus_hub
//   One shared write bus feeding NUM_DROPS receive FIFOs. The bus supports
//   addressed unicast writes and broadcast writes. Broadcast is either atomic
//   (stall until every drop has room) or best-effort (full drops skip the word
//   and raise a sticky overflow flag). A unicast to a non-existent drop is
//   accepted and discarded, and it raises a sticky address-error flag.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-low reset
//   bus_data    in   WIDTH-bit write word
//   bus_addr    in   target drop index (AW = clog2(NUM_DROPS) bits)
//   bus_bcast   in   1 = write all drops, bus_addr ignored
//   bus_valid   in   master offers a word
//   bus_ready   out  hub accepts this cycle (registered state only)
//   drop_data   out  head word per drop, drop i at [i*WIDTH +: WIDTH]
//   drop_valid  out  per-drop FIFO not empty
//   drop_ready  in   per-drop consumer pops the head word
//   drop_count  out  per-drop occupancy, drop i at [i*CW +: CW]
//   drop_ovf    out  sticky: best-effort broadcast skipped this drop
//   addr_err    out  sticky: unicast accepted with bus_addr >= NUM_DROPS
//   err_clr     in   synchronous clear of drop_ovf/addr_err (wins over set)
// ----------------------------------------------------------------------------
module multi_drop_bus_hub
    import mdb_pkg::*;
#(
    parameter  int WIDTH      = 8,
    parameter  int NUM_DROPS  = 3,
    parameter  int DEPTH      = 4,
    parameter  int BCAST_MODE = BCAST_ATOMIC,
    localparam int AW         = clog2_safe(NUM_DROPS),
    localparam int CW         = clog2_safe(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          bus_data,
    input  logic [AW-1:0]             bus_addr,
    input  logic                      bus_bcast,
    input  logic                      bus_valid,
    output logic                      bus_ready,
    output logic [NUM_DROPS*WIDTH-1:0] drop_data,
    output logic [NUM_DROPS-1:0]      drop_valid,
    input  logic [NUM_DROPS-1:0]      drop_ready,
    output logic [NUM_DROPS*CW-1:0]   drop_count,
    output logic [NUM_DROPS-1:0]      drop_ovf,
    output logic                      addr_err,
    input  logic                      err_clr
);

    logic [NUM_DROPS-1:0] full;
    logic [NUM_DROPS-1:0] empty;
    logic [NUM_DROPS-1:0] push;
    logic [NUM_DROPS-1:0] ovf_set;
    logic [NUM_DROPS-1:0] drop_ovf_q, drop_ovf_d;
    logic                 addr_err_q, addr_err_d;
    logic                 live_q;
    logic                 addr_in_range;
    logic                 sel_full;
    logic                 accept;
    logic                 addr_err_set;

    always_comb begin
        addr_in_range = ({{(32-AW){1'b0}}, bus_addr} < 32'(NUM_DROPS));

        // Loop decode instead of full[bus_addr] keeps an out-of-range
        // address from indexing past the end of the vector.
        sel_full = 1'b0;
        for (int i = 0; i < NUM_DROPS; i++) begin
            if (bus_addr == AW'(i)) begin
                sel_full = full[i];
            end
        end

        // live_q holds bus_ready low while in reset. Only registered
        // state feeds this path, and drop_ready is not used, so a pop
        // never frees a slot for a write in the same cycle.
        if (!live_q) begin
            bus_ready = 1'b0;
        end else if (bus_bcast) begin
            bus_ready = (BCAST_MODE == BCAST_BEST) ? 1'b1 : ~|full;
        end else if (!addr_in_range) begin
            bus_ready = 1'b1;
        end else begin
            bus_ready = ~sel_full;
        end

        accept = bus_valid & bus_ready;

        for (int i = 0; i < NUM_DROPS; i++) begin
            push[i]    = accept & ~full[i] &
                         (bus_bcast | (addr_in_range & (bus_addr == AW'(i))));
            // Only reachable in best-effort mode. An atomic broadcast is
            // accepted only when no drop is full.
            ovf_set[i] = accept & bus_bcast & full[i];
        end
        addr_err_set = accept & ~bus_bcast & ~addr_in_range;

        drop_ovf_d = err_clr ? '0   : (drop_ovf_q | ovf_set);
        addr_err_d = err_clr ? 1'b0 : (addr_err_q | addr_err_set);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_ovf_q <= '0;
            addr_err_q <= 1'b0;
            live_q     <= 1'b0;
        end else begin
            drop_ovf_q <= drop_ovf_d;
            addr_err_q <= addr_err_d;
            live_q     <= 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_DROPS; g++) begin : g_drop
        mdb_drop_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (push[g]),
            .wdata_i (bus_data),
            .pop_i   (drop_ready[g]),
            .rdata_o (drop_data[g*WIDTH +: WIDTH]),
            .count_o (drop_count[g*CW +: CW]),
            .full_o  (full[g]),
            .empty_o (empty[g])
        );
        assign drop_valid[g] = ~empty[g];
    end

    assign drop_ovf = drop_ovf_q;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_multi_drop_bus_hub.sv
// ----------------------------------------------------------------------------
// tb_multi_drop_bus_hub
//   Scoreboard bench for multi_drop_bus_hub (WIDTH=8, NUM_DROPS=3, DEPTH=4).
//   u_dut uses atomic broadcast and u_best uses best-effort broadcast.
//   Accepted writes queue their expected words per drop. A monitor compares
//   every popped head word against those queues.
// ----------------------------------------------------------------------------
module tb_multi_drop_bus_hub;

    logic        clk;
    logic        rst;

    logic [7:0]  bus_data;
    logic [1:0]  bus_addr;
    logic        bus_bcast, bus_valid, bus_ready;
    logic [23:0] drop_data;
    logic [2:0]  drop_valid, drop_ready, drop_ovf;
    logic [8:0]  drop_count;
    logic        addr_err, err_clr;

    logic [7:0]  b_bus_data;
    logic [1:0]  b_bus_addr;
    logic        b_bus_bcast, b_bus_valid, b_bus_ready;
    logic [23:0] b_drop_data;
    logic [2:0]  b_drop_valid, b_drop_ready, b_drop_ovf;
    logic [8:0]  b_drop_count;
    logic        b_addr_err, b_err_clr;

    int total;
    int bad;

    logic [7:0] expq [3][$];

    multi_drop_bus_hub #(.WIDTH(8), .NUM_DROPS(3), .DEPTH(4), .BCAST_MODE(0)) u_dut (
        .clk(clk), .rst(rst),
        .bus_data(bus_data), .bus_addr(bus_addr), .bus_bcast(bus_bcast),
        .bus_valid(bus_valid), .bus_ready(bus_ready),
        .drop_data(drop_data), .drop_valid(drop_valid), .drop_ready(drop_ready),
        .drop_count(drop_count), .drop_ovf(drop_ovf), .addr_err(addr_err),
        .err_clr(err_clr)
    );

    multi_drop_bus_hub #(.WIDTH(8), .NUM_DROPS(3), .DEPTH(4), .BCAST_MODE(1)) u_best (
        .clk(clk), .rst(rst),
        .bus_data(b_bus_data), .bus_addr(b_bus_addr), .bus_bcast(b_bus_bcast),
        .bus_valid(b_bus_valid), .bus_ready(b_bus_ready),
        .drop_data(b_drop_data), .drop_valid(b_drop_valid), .drop_ready(b_drop_ready),
        .drop_count(b_drop_count), .drop_ovf(b_drop_ovf), .addr_err(b_addr_err),
        .err_clr(b_err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every pop of a valid head word is checked against the queue.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            for (int i = 0; i < 3; i++) begin
                if (drop_valid[i] && drop_ready[i]) begin
                    total++;
                    if (expq[i].size() == 0) begin
                        bad++;
                        $display("FAIL pop_drop%0d: got %0h expected no word", i, drop_data[i*8 +: 8]);
                    end else begin
                        logic [7:0] e;
                        e = expq[i].pop_front();
                        if (drop_data[i*8 +: 8] !== e) begin
                            bad++;
                            $display("FAIL pop_drop%0d: got %0h expected %0h", i, drop_data[i*8 +: 8], e);
                        end
                    end
                end
            end
        end
    end

    // Unicast write on u_dut, bounded wait for acceptance.
    task automatic bus_write(input logic [7:0] d, input logic [1:0] a);
        bit acc;
        acc       = 1'b0;
        bus_data  = d;
        bus_addr  = a;
        bus_bcast = 1'b0;
        bus_valid = 1'b1;
        for (int n = 0; n < 20 && !acc; n++) begin
            @(negedge clk);
            if (bus_ready === 1'b1) acc = 1'b1;
            @(posedge clk);
        end
        if (acc && a != 2'd3) expq[a].push_back(d);
        #1 bus_valid = 1'b0;
        total++;
        if (!acc) begin
            bad++;
            $display("FAIL write_accept: got timeout expected accept of %0h to addr %0d", d, a);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b0;
        bus_data = '0; bus_addr = '0; bus_bcast = 1'b0; bus_valid = 1'b1;
        drop_ready = '0; err_clr = 1'b0;
        b_bus_data = '0; b_bus_addr = '0; b_bus_bcast = 1'b0; b_bus_valid = 1'b0;
        b_drop_ready = '0; b_err_clr = 1'b0;

        // Reset state
        #3;
        check("rst_ready", bus_ready, 0);
        check("rst_valid", drop_valid, 0);
        check("rst_data", drop_data, 0);
        check("rst_count", drop_count, 0);
        check("rst_ovf", drop_ovf, 0);
        check("rst_addr_err", addr_err, 0);
        bus_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 1: unicast to each drop
        check("s1_valid_before", drop_valid, 3'b000);
        bus_write(8'h36, 2'd0);
        check("s1_valid_d0", drop_valid, 3'b001);
        bus_write(8'h4F, 2'd1);
        check("s1_valid_d1", drop_valid, 3'b011);
        bus_write(8'hF6, 2'd2);
        check("s1_valid_d2", drop_valid, 3'b111);
        check("s1_count", drop_count, 9'h049);
        check("s1_head2", drop_data[23:16], 8'hF6);
        drop_ready = 3'b111;
        @(posedge clk);
        #1 drop_ready = 3'b000;
        check("s1_valid_after", drop_valid, 3'b000);
        check("s1_data_empty", drop_data, 0);

        // 2: fill drop 1, backpressure only on addr 1, no bypass
        for (int k = 0; k < 4; k++) bus_write(8'(8'h11 + k), 2'd1);
        check("s2_count_full", drop_count, 9'h020);
        bus_addr = 2'd1;
        @(negedge clk);
        check("s2_ready_full", bus_ready, 0);
        bus_addr = 2'd0;
        #1 check("s2_ready_other", bus_ready, 1);
        @(posedge clk);
        #1 bus_addr = 2'd1;
        drop_ready = 3'b010;
        @(negedge clk);
        check("s2_no_bypass", bus_ready, 0);
        @(posedge clk);
        #1 drop_ready = 3'b000;
        check("s2_ready_back", bus_ready, 1);
        check("s2_count_3", drop_count, 9'h018);
        drop_ready = 3'b010;
        repeat (3) @(posedge clk);
        #1 drop_ready = 3'b000;
        check("s2_drained", drop_valid, 3'b000);

        // 3a: atomic broadcast stalls on full drop 2
        for (int k = 0; k < 4; k++) bus_write(8'(8'h21 + k), 2'd2);
        bus_data = 8'hAA; bus_bcast = 1'b1; bus_valid = 1'b1;
        @(negedge clk);
        check("s3_stall0", bus_ready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("s3_stall1", bus_ready, 0);
        @(posedge clk);
        #1 drop_ready = 3'b100;
        @(negedge clk);
        check("s3_no_bypass", bus_ready, 0);
        @(posedge clk);
        #1 drop_ready = 3'b000;
        @(negedge clk);
        check("s3_ready_after_pop", bus_ready, 1);
        @(posedge clk);
        for (int i = 0; i < 3; i++) expq[i].push_back(8'hAA);
        #1 bus_valid = 1'b0; bus_bcast = 1'b0;
        check("s3_count", drop_count, 9'h109);
        check("s3_ovf_atomic", drop_ovf, 3'b000);
        drop_ready = 3'b111;
        repeat (4) @(posedge clk);
        #1 drop_ready = 3'b000;
        check("s3_drained", drop_valid, 3'b000);

        // 3b: best-effort broadcast on u_best
        b_bus_addr = 2'd2;
        for (int k = 0; k < 4; k++) begin
            b_bus_data = 8'(8'h30 + k);
            b_bus_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        check("s3b_fill", b_drop_count, 9'h100);
        b_bus_data = 8'hAA; b_bus_bcast = 1'b1;
        @(negedge clk);
        check("s3b_ready", b_bus_ready, 1);
        @(posedge clk);
        #1;
        check("s3b_ovf", b_drop_ovf, 3'b100);
        check("s3b_count", b_drop_count, 9'h109);
        check("s3b_head0", b_drop_data[7:0], 8'hAA);
        check("s3b_head2", b_drop_data[23:16], 8'h30);
        b_bus_data = 8'hBB; b_err_clr = 1'b1;
        @(posedge clk);
        #1 b_bus_valid = 1'b0; b_bus_bcast = 1'b0; b_err_clr = 1'b0;
        check("s3b_clr_priority", b_drop_ovf, 3'b000);
        check("s3b_count2", b_drop_count, 9'h112);
        check("s3b_addr_err", b_addr_err, 0);

        // 4: pointer wrap with a pop every cycle
        drop_ready = 3'b001; bus_addr = 2'd0; bus_bcast = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bus_data = 8'(8'h50 + k);
            bus_valid = 1'b1;
            @(negedge clk);
            check("s4_ready", bus_ready, 1);
            @(posedge clk);
            expq[0].push_back(bus_data);
            #1 check("s4_count", drop_count[2:0], 1);
        end
        bus_valid = 1'b0;
        @(posedge clk);
        #1 drop_ready = 3'b000;
        check("s4_count_end", drop_count, 0);

        // 5: out-of-range unicast and err_clr
        bus_write(8'h77, 2'd3);
        check("s5_addr_err", addr_err, 1);
        check("s5_no_write", drop_valid, 3'b000);
        check("s5_no_count", drop_count, 0);
        bus_addr = 2'd3; bus_valid = 1'b1; err_clr = 1'b1;
        @(posedge clk);
        #1 bus_valid = 1'b0; err_clr = 1'b0;
        check("s5_clr_priority", addr_err, 0);
        bus_write(8'h78, 2'd3);
        check("s5_addr_err2", addr_err, 1);
        err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        check("s5_clr", addr_err, 0);

        // 6: asynchronous reset mid-stream
        bus_write(8'h61, 2'd0);
        bus_write(8'h62, 2'd0);
        bus_write(8'h63, 2'd1);
        bus_write(8'h99, 2'd3);
        check("s6_pre_count", drop_count, 9'h00A);
        check("s6_pre_err", addr_err, 1);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("s6_ready", bus_ready, 0);
        check("s6_valid", drop_valid, 0);
        check("s6_data", drop_data, 0);
        check("s6_count", drop_count, 0);
        check("s6_addr_err", addr_err, 0);
        check("s6_best_count", b_drop_count, 0);
        check("s6_best_valid", b_drop_valid, 0);
        for (int i = 0; i < 3; i++) expq[i].delete();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus_write(8'h36, 2'd0);
        check("s6_valid_after", drop_valid, 3'b001);
        check("s6_head", drop_data[7:0], 8'h36);
        drop_ready = 3'b001;
        @(posedge clk);
        #1 drop_ready = 3'b000;
        check("s6_empty", drop_valid, 3'b000);

        for (int i = 0; i < 3; i++) check("leftover", expq[i].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
